// File: rtl/conv_pkg.sv
// Shared definitions for the conv window generator.
//   state_e  : frame sequencer states
//   ModeDw/ModePw : cfg_mode encodings
//   win_idx  : flat tap index of (ch, ky, kx) inside an output window
package conv_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StRowPad,
      StBotPad,
      StDone
   } state_e;

   localparam logic ModeDw = 1'b0;
   localparam logic ModePw = 1'b1;

   function automatic int unsigned win_idx(input int unsigned ch, input int unsigned ky,
                                           input int unsigned kx, input int unsigned k);
      return (ch * k + ky) * k + kx;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One raster line of pixels, simple dual-port, 1-cycle registered read.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write column
//   wr_data : pixel written
//   rd_addr : read column
//   rd_data : pixel at rd_addr as it was before any same-edge write
module conv_line_buffer #(
   parameter int unsigned DEPTH = 320,
   parameter int unsigned WIDTH = 72,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream -> KxK per-channel windows (depthwise) or straight passthrough (pointwise).
// Optional build macro: CONV_ZERO_PAD_EN adds 'same' zero padding in depthwise mode.
//   clk, rst             : clock, synchronous active-high reset
//   cfg_start            : start a frame with cfg_mode/cfg_stride/cfg_cols/cfg_rows (idle only)
//   in_data/valid/ready  : input pixel stream
//   out_data/valid/ready : output window stream, single register stage
//   busy                 : frame in progress
//   frame_done           : one-cycle pulse with the final output handshake
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int unsigned CH_NUM     = 9,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned K          = 3,
   parameter int unsigned MAX_COLS   = 320,
   parameter int unsigned COL_W      = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_start,
   input  logic                           cfg_mode,
   input  logic                           cfg_stride,
   input  logic [COL_W-1:0]               cfg_cols,
   input  logic [COL_W-1:0]               cfg_rows,
   input  logic [CH_NUM*DATA_WIDTH-1:0]   in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [CH_NUM*K*K*DATA_WIDTH-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           frame_done
);

   localparam int unsigned PXW = CH_NUM * DATA_WIDTH;
   localparam int unsigned OW  = PXW * K * K;
   localparam int unsigned AW  = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam logic [COL_W-1:0] ONE = COL_W'(1);
   localparam logic [COL_W-1:0] KM1 = COL_W'(K - 1);

   state_e state_q, state_d;
   logic mode_q, stride_q, out_valid_q;
   logic [COL_W-1:0] cols_q, rows_q, col_q, col_d, row_q, row_d, col_wrap, eoff;
   logic [OW-1:0] out_data_q, win_out;
   logic [PXW-1:0] pix;
   logic [PXW-1:0] col_vec [K];
   logic [PXW-1:0] win_q   [K][K];
   logic [PXW-1:0] win_sh  [K][K];
   logic [AW-1:0] rd_addr;
   logic slot_free, adv, emit, last_col, last_row;

`ifdef CONV_ZERO_PAD_EN
   localparam logic [COL_W-1:0] PC = COL_W'((K - 1) / 2);
   logic pad_on, last_col_pad, last_row_pad;
   assign pad_on       = (mode_q == ModeDw) && (K > 1);
   assign last_col_pad = (col_q == cols_q - ONE + PC);
   assign last_row_pad = (row_q == rows_q - ONE + PC);
   assign col_wrap     = pad_on ? cols_q - ONE + PC : cols_q - ONE;
   // Padded windows are anchored P beats after their centre instead of K-1.
   assign eoff         = pad_on ? PC : KM1;
   assign adv = (state_q == StRun) ? (in_valid & slot_free) :
                ((state_q == StRowPad) || (state_q == StBotPad)) ? slot_free : 1'b0;
`else
   assign col_wrap = cols_q - ONE;
   assign eoff     = KM1;
   assign adv      = (state_q == StRun) & in_valid & slot_free;
`endif

   assign slot_free = ~out_valid_q | out_ready;
   assign pix       = (state_q == StRun) ? in_data : '0;
   assign last_col  = (col_q == cols_q - ONE);
   assign last_row  = (row_q == rows_q - ONE);
   assign emit = (mode_q == ModePw) ||
                 ((row_q >= eoff) && (col_q >= eoff) &&
                  (~stride_q || (~(row_q[0] ^ eoff[0]) && ~(col_q[0] ^ eoff[0]))));

   // Next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (cfg_start) state_d = StRun;
         StRun: begin
            if (adv && last_col) begin
`ifdef CONV_ZERO_PAD_EN
               if (pad_on)        state_d = last_row ? StBotPad : StRowPad;
               else if (last_row) state_d = StDone;
`else
               if (last_row) state_d = StDone;
`endif
            end
         end
`ifdef CONV_ZERO_PAD_EN
         StRowPad: if (adv && last_col_pad) state_d = StRun;
         StBotPad: if (adv && last_col_pad && last_row_pad) state_d = StDone;
`endif
         StDone: if (slot_free) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Raster counters
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (state_q == StIdle) begin
         if (cfg_start) begin
            col_d = '0;
            row_d = '0;
         end
      end else if (adv) begin
         if (col_q == col_wrap) begin
            col_d = '0;
            row_d = row_q + ONE;
         end else begin
            col_d = col_q + ONE;
         end
      end
   end

   // Outputs
   always_comb begin
      busy       = (state_q != StIdle);
      in_ready   = (state_q == StRun) & slot_free;
      frame_done = (state_q == StDone) & slot_free;
      out_valid  = out_valid_q;
      out_data   = out_data_q;
   end

   // Reading at the next column keeps the 1-cycle RAM latency hidden; pad columns map to 0.
   assign rd_addr    = (col_d < cols_q) ? col_d[AW-1:0] : '0;
   assign col_vec[K-1] = pix;

   for (genvar j = 0; j < int'(K) - 1; j++) begin : g_lb
      logic [PXW-1:0] rd;
      conv_line_buffer #(
         .DEPTH(MAX_COLS),
         .WIDTH(PXW)
      ) u_lb (
         .clk    (clk),
         .wr_en  (adv && (col_q < cols_q)),
         .wr_addr(col_q[AW-1:0]),
         .wr_data(col_vec[K-1-j]),
         .rd_addr(rd_addr),
         .rd_data(rd)
      );
      assign col_vec[K-2-j] = rd;
   end

   always_comb begin
      for (int ky = 0; ky < int'(K); ky++) begin
         for (int kx = 0; kx < int'(K) - 1; kx++) win_sh[ky][kx] = win_q[ky][kx+1];
         win_sh[ky][K-1] = col_vec[ky];
      end
   end

   always_comb begin
      logic [DATA_WIDTH-1:0] tap;
      tap     = '0;
      win_out = '0;
      if (mode_q == ModePw) begin
         win_out[PXW-1:0] = pix;
      end else begin
         for (int ch = 0; ch < int'(CH_NUM); ch++) begin
            for (int ky = 0; ky < int'(K); ky++) begin
               for (int kx = 0; kx < int'(K); kx++) begin
                  tap = win_sh[ky][kx][ch*DATA_WIDTH +: DATA_WIDTH];
`ifdef CONV_ZERO_PAD_EN
                  // Tap frame coordinate is (row_q-(K-1)+ky, col_q-(K-1)+kx).
                  if (pad_on && !((int'(row_q) + ky >= int'(K) - 1) &&
                                  (int'(row_q) + ky <  int'(rows_q) + int'(K) - 1) &&
                                  (int'(col_q) + kx >= int'(K) - 1) &&
                                  (int'(col_q) + kx <  int'(cols_q) + int'(K) - 1)))
                     tap = '0;
`endif
                  win_out[win_idx(ch, ky, kx, K)*DATA_WIDTH +: DATA_WIDTH] = tap;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         cols_q      <= '0;
         rows_q      <= '0;
         mode_q      <= ModeDw;
         stride_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         if ((state_q == StIdle) && cfg_start) begin
            cols_q   <= cfg_cols;
            rows_q   <= cfg_rows;
            mode_q   <= cfg_mode;
            stride_q <= cfg_stride;
         end
         if (adv && emit) begin
            out_valid_q <= 1'b1;
            out_data_q  <= win_out;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Window taps are masked by the emit rule or padding, so no reset is needed.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int ky = 0; ky < int'(K); ky++)
            for (int kx = 0; kx < int'(K); kx++) win_q[ky][kx] <= win_sh[ky][kx];
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

   localparam int CH   = 9;
   localparam int DW   = 8;
   localparam int K    = 3;
   localparam int MAXC = 320;
   localparam int CW   = 9;
   localparam int MAXR = 9;
   localparam int PXW  = CH * DW;
   localparam int OW   = PXW * K * K;
`ifdef CONV_ZERO_PAD_EN
   localparam bit PadEn = 1'b1;
`else
   localparam bit PadEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, cfg_start, cfg_mode, cfg_stride;
   logic [CW-1:0] cfg_cols, cfg_rows;
   logic [PXW-1:0] in_data;
   logic in_valid, in_ready, out_valid, out_ready, busy, frame_done;
   logic [OW-1:0] out_data;

   always #5 clk = ~clk;

   conv_window_gen #(
      .CH_NUM(CH), .DATA_WIDTH(DW), .K(K), .MAX_COLS(MAXC), .COL_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
      .cfg_stride(cfg_stride), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done)
   );

   typedef struct {
      bit mode;
      bit stride;
      int cols;
      int rows;
      bit ramp;
      int vpct;
      int rpct;     // negative: toggle 1,0,1,0...
      int exp_cnt;
   } vec_t;

   vec_t vecs [7];
   int total = 0;
   int bad = 0;
   logic [PXW-1:0] frame [MAXR][MAXC];
   logic [OW-1:0] exp_q [$];
   logic [OW-1:0] win_first, win_second, win_last;

   task automatic chk(input bit ok, input string name, input string detail);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   task automatic chk_taps(input logic [OW-1:0] w, input int ky_lo, input int ky_hi,
                           input int vals [9], input string name);
      bit ok = 1'b1;
      for (int ch = 0; ch < CH; ch++)
         for (int ky = ky_lo; ky <= ky_hi; ky++)
            for (int kx = 0; kx < K; kx++)
               if (w[((ch*K+ky)*K+kx)*DW +: DW] !== DW'(vals[ky*K+kx])) ok = 1'b0;
      chk(ok, name, $sformatf("got %h want taps %p rows %0d..%0d", w, vals, ky_lo, ky_hi));
   endtask

   task automatic fill_frame(input vec_t v);
      logic [DW-1:0] b;
      for (int r = 0; r < v.rows; r++)
         for (int c = 0; c < v.cols; c++)
            for (int ch = 0; ch < CH; ch++) begin
               b = v.ramp ? DW'(r * v.cols + c) : DW'($urandom);
               frame[r][c][ch*DW +: DW] = b;
            end
   endtask

   // Expected windows straight from the frame: anchor row/col stepping by stride,
   // taps offset from the anchor, anything outside the frame reads as zero.
   task automatic build_expected(input vec_t v);
      int s, off, start, rr, cc;
      logic [OW-1:0] w;
      exp_q.delete();
      s     = v.stride ? 2 : 1;
      off   = PadEn ? (K - 1) / 2 : K - 1;
      start = PadEn ? 0 : K - 1;
      if (v.mode) begin
         for (int r = 0; r < v.rows; r++)
            for (int c = 0; c < v.cols; c++) begin
               w = '0;
               w[PXW-1:0] = frame[r][c];
               exp_q.push_back(w);
            end
      end else begin
         for (int r = start; r < v.rows; r += s)
            for (int c = start; c < v.cols; c += s) begin
               w = '0;
               for (int ky = 0; ky < K; ky++)
                  for (int kx = 0; kx < K; kx++) begin
                     rr = r - off + ky;
                     cc = c - off + kx;
                     if (rr >= 0 && rr < v.rows && cc >= 0 && cc < v.cols)
                        for (int ch = 0; ch < CH; ch++)
                           w[((ch*K+ky)*K+kx)*DW +: DW] = frame[rr][cc][ch*DW +: DW];
                  end
               exp_q.push_back(w);
            end
      end
   endtask

   task automatic run_frame(input vec_t v, input int abort_after);
      int npix, idx, cyc, budget, n_out;
      bit in_hs, out_hs, finished, tog, aborted;
      fill_frame(v);
      build_expected(v);
      npix = v.rows * v.cols;
      budget = 20 * npix + 100;
      idx = 0; cyc = 0; n_out = 0;
      in_hs = 0; finished = 0; tog = 1; aborted = 0;
      @(negedge clk);
      cfg_mode = v.mode; cfg_stride = v.stride;
      cfg_cols = CW'(v.cols); cfg_rows = CW'(v.rows);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      chk(busy === 1'b1, "busy_after_start", $sformatf("got %b want 1", busy));
      while (!finished && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (in_hs) begin
            in_valid = 1'b0;
            idx++;
         end
         if (!in_valid && idx < npix && $urandom_range(0, 99) < v.vpct) begin
            in_valid = 1'b1;
            in_data  = frame[idx / v.cols][idx % v.cols];
         end
         if (v.rpct < 0) begin
            out_ready = tog;
            tog = ~tog;
         end else begin
            out_ready = ($urandom_range(0, 99) < v.rpct);
         end
         #1;
         in_hs  = in_valid && in_ready;
         out_hs = out_valid && out_ready;
         if (out_valid) begin
            if (exp_q.size() == 0)
               chk(1'b0, "extra_window", $sformatf("got %h want none", out_data));
            else
               chk(out_data === exp_q[0], "window",
                   $sformatf("n=%0d got %h want %h", n_out, out_data, exp_q[0]));
         end
         if (out_valid && !out_ready)
            chk(in_ready === 1'b0, "stall_in_ready", $sformatf("got %b want 0", in_ready));
         if (frame_done) begin
            chk(out_hs && exp_q.size() == 1, "frame_done_on_last",
                $sformatf("hs=%b left=%0d want hs=1 left=1", out_hs, exp_q.size()));
            finished = 1'b1;
         end
         if (out_hs) begin
            if (n_out == 0) win_first = out_data;
            if (n_out == 1) win_second = out_data;
            win_last = out_data;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_out++;
         end
         if (abort_after > 0 && n_out == abort_after) begin
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         @(negedge clk);
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         #1;
         chk(out_valid === 1'b0 && out_data === '0, "abort_out_cleared",
             $sformatf("got valid=%b data=%h want 0", out_valid, out_data));
         chk(busy === 1'b0 && in_ready === 1'b0, "abort_idle",
             $sformatf("got busy=%b in_ready=%b want 0 0", busy, in_ready));
         chk(frame_done === 1'b0, "abort_no_done", $sformatf("got %b want 0", frame_done));
      end else begin
         in_valid = 1'b0;
         chk(finished, "frame_finished", $sformatf("got cycles=%0d want done within %0d", cyc, budget));
         chk(n_out == v.exp_cnt, "window_count", $sformatf("got %0d want %0d", n_out, v.exp_cnt));
         chk(exp_q.size() == 0, "windows_left", $sformatf("got %0d want 0", exp_q.size()));
         chk(idx == npix, "pixels_accepted", $sformatf("got %0d want %0d", idx, npix));
         @(negedge clk);
         #1;
         chk(busy === 1'b0 && frame_done === 1'b0, "idle_after_done",
             $sformatf("got busy=%b done=%b want 0 0", busy, frame_done));
      end
   endtask

   initial begin
      int t_first [9];
      int t_row   [9];
      int t_zero  [9];
      t_first = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      t_row   = '{2, 3, 4, 0, 0, 0, 0, 0, 0};
      t_zero  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

      rst = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_stride = 1'b0;
      cfg_cols = '0; cfg_rows = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk(out_valid === 1'b0, "reset_out_valid", $sformatf("got %b want 0", out_valid));
      chk(out_data === '0, "reset_out_data", $sformatf("got %h want 0", out_data));
      chk(in_ready === 1'b0, "reset_in_ready", $sformatf("got %b want 0", in_ready));
      chk(busy === 1'b0 && frame_done === 1'b0, "reset_busy_done",
          $sformatf("got busy=%b done=%b want 0 0", busy, frame_done));
      rst = 1'b0;

`ifdef CONV_ZERO_PAD_EN
      vecs[0] = '{0, 0, 5, 5, 1, 100, 100, 25};
      vecs[1] = '{0, 1, 5, 5, 1, 100, 100, 9};
      vecs[2] = '{1, 0, 4, 3, 1, 100, -1, 12};
      vecs[3] = '{0, 0, 320, 6, 0, 60, 60, 1920};
      vecs[4] = '{0, 1, 7, 9, 0, 70, 50, 20};
      vecs[5] = '{1, 1, 10, 5, 0, 50, 70, 50};
      vecs[6] = '{0, 0, 4, 4, 1, 100, 100, 16};
`else
      vecs[0] = '{0, 0, 5, 5, 1, 100, 100, 9};
      vecs[1] = '{0, 1, 5, 5, 1, 100, 100, 4};
      vecs[2] = '{1, 0, 4, 3, 1, 100, -1, 12};
      vecs[3] = '{0, 0, 320, 6, 0, 60, 60, 1272};
      vecs[4] = '{0, 1, 7, 9, 0, 70, 50, 12};
      vecs[5] = '{1, 1, 10, 5, 0, 50, 70, 50};
      vecs[6] = '{0, 0, 3, 3, 1, 100, 100, 1};
`endif

      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i], 0);
`ifdef CONV_ZERO_PAD_EN
         if (i == 6) begin
            t_first = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
            chk_taps(win_first, 0, 2, t_first, "pad_first_window");
            chk_taps(win_last, 2, 2, t_zero, "pad_last_bottom_row");
         end
`else
         if (i == 0) chk_taps(win_first, 0, 2, t_first, "ramp_first_window");
         if (i == 1) chk_taps(win_second, 0, 0, t_row, "stride2_second_top_row");
`endif
      end

      // Abort at window 4, then the same frame again from scratch.
      run_frame(vecs[0], 4);
      run_frame(vecs[0], 0);
`ifndef CONV_ZERO_PAD_EN
      chk_taps(win_first, 0, 2, t_first, "rerun_first_window");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
